// File: rtl/prbs_engine.sv
// rtl/prbs_engine.sv - parametrised PRBS generator and self-synchronising checker
// Generator and checker share one Fibonacci LFSR step definition.
module prbs_engine #(
    parameter int              WIDTH      = 16,
    parameter logic [WIDTH-1:0] TAPS      = 16'hD008,
    parameter int              STEP       = 1,
    parameter logic [WIDTH-1:0] SEED      = {WIDTH{1'b1}},
    parameter int              LOCK_WORDS = 4,
    parameter int              BAD_WORDS  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gen_en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [STEP-1:0]  gen_data,
    output logic             gen_valid,
    input  logic             chk_valid,
    input  logic [STEP-1:0]  chk_data,
    input  logic             err_clr,
    output logic             chk_locked,
    output logic [31:0]      err_cnt,
    output logic             err_word
);

    // Returns {state after STEP steps, emitted bits with the oldest in the MSB}.
    function automatic logic [WIDTH+STEP-1:0] lfsr_advance(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] st;
        logic [STEP-1:0]  bits;
        logic             fb;
        st   = s;
        bits = '0;
        for (int i = 0; i < STEP; i++) begin
            fb             = ^(st & TAPS);
            st             = {st[WIDTH-2:0], fb};
            bits[STEP-1-i] = fb;
        end
        return {st, bits};
    endfunction

    function automatic logic [31:0] popcount(input logic [STEP-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < STEP; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} chk_state_t;

    logic [WIDTH-1:0]      gen_state_q, gen_state_d;
    logic [STEP-1:0]       gen_data_q, gen_data_d;
    logic                  gen_valid_q, gen_valid_d;
    logic [WIDTH+STEP-1:0] gen_adv;

    chk_state_t            state_q, state_d;
    logic [WIDTH-1:0]      pred_q, pred_d;
    logic [31:0]           fill_q, fill_d;
    logic [31:0]           clean_q, clean_d;
    logic [31:0]           bad_q, bad_d;
    logic [31:0]           err_q, err_d;
    logic                  err_word_q, err_word_d;
    logic [WIDTH+STEP-1:0] pred_adv;
    logic [STEP-1:0]       mismatch;
    logic [32:0]           err_sum;

    always_comb begin
        gen_adv     = lfsr_advance(gen_state_q);
        gen_state_d = gen_state_q;
        gen_data_d  = gen_data_q;
        gen_valid_d = 1'b0;
        if (seed_load) begin
            gen_state_d = (seed_in == '0) ? SEED : seed_in;
        end else if (gen_state_q == '0) begin
            gen_state_d = SEED;
        end else if (gen_en) begin
            gen_state_d = gen_adv[WIDTH+STEP-1:STEP];
            gen_data_d  = gen_adv[STEP-1:0];
            gen_valid_d = 1'b1;
        end
    end

    always_comb begin
        pred_adv   = lfsr_advance(pred_q);
        mismatch   = pred_adv[STEP-1:0] ^ chk_data;
        state_d    = state_q;
        pred_d     = pred_q;
        fill_d     = fill_q;
        clean_d    = clean_q;
        bad_d      = bad_q;
        err_word_d = 1'b0;
        err_sum    = {1'b0, (err_clr ? 32'd0 : err_q)};
        if (chk_valid) begin
            unique case (state_q)
                HUNT: begin
                    pred_d = WIDTH'({pred_q, chk_data});
                    fill_d = fill_q + 32'(STEP);
                    if (fill_d >= 32'(WIDTH)) begin
                        state_d = VERIFY;
                        clean_d = '0;
                    end
                end
                VERIFY: begin
                    // Free-run on the prediction so a single bad bit cannot poison pred.
                    pred_d = pred_adv[WIDTH+STEP-1:STEP];
                    if (pred_q == '0 || mismatch != '0) begin
                        state_d = HUNT;
                        fill_d  = '0;
                    end else begin
                        clean_d = clean_q + 32'd1;
                        if (clean_d >= 32'(LOCK_WORDS)) begin
                            state_d = LOCKED;
                            bad_d   = '0;
                        end
                    end
                end
                LOCKED: begin
                    pred_d  = pred_adv[WIDTH+STEP-1:STEP];
                    err_sum = err_sum + {1'b0, popcount(mismatch)};
                    if (mismatch != '0) begin
                        err_word_d = 1'b1;
                        bad_d      = bad_q + 32'd1;
                        if (bad_d >= 32'(BAD_WORDS)) begin
                            state_d = HUNT;
                            fill_d  = '0;
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        err_d = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gen_state_q <= SEED;
            gen_data_q  <= '0;
            gen_valid_q <= 1'b0;
            state_q     <= HUNT;
            pred_q      <= '0;
            fill_q      <= '0;
            clean_q     <= '0;
            bad_q       <= '0;
            err_q       <= '0;
            err_word_q  <= 1'b0;
        end else begin
            gen_state_q <= gen_state_d;
            gen_data_q  <= gen_data_d;
            gen_valid_q <= gen_valid_d;
            state_q     <= state_d;
            pred_q      <= pred_d;
            fill_q      <= fill_d;
            clean_q     <= clean_d;
            bad_q       <= bad_d;
            err_q       <= err_d;
            err_word_q  <= err_word_d;
        end
    end

    assign gen_data   = gen_data_q;
    assign gen_valid  = gen_valid_q;
    assign chk_locked = (state_q == LOCKED);
    assign err_cnt    = err_q;
    assign err_word   = err_word_q;

endmodule

// File: tb/tb_prbs_engine.sv
// tb/tb_prbs_engine.sv - directed checks of prbs_engine generator, checker and saturation
module tb_prbs_engine;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, gen_en, seed_load, err_clr;
    logic [15:0] seed_in;
    logic        flip1;
    logic [1:0]  flip2;

    logic        d_gd, d_gv, d_lk, d_ew;
    logic [31:0] d_ec;
    logic [1:0]  s2_gd;
    logic        s2_gv, s2_lk, s2_ew;
    logic [31:0] s2_ec;
    logic [3:0]  s4_gd;
    logic        s4_gv, s4_lk, s4_ew;
    logic [31:0] s4_ec;
    logic [7:0]  w_gd;
    logic        w_gv, w_lk, w_ew;
    logic [31:0] w_ec;

    prbs_engine u_def (
        .clk(clk), .rst(rst), .gen_en(gen_en), .seed_load(seed_load), .seed_in(seed_in),
        .gen_data(d_gd), .gen_valid(d_gv), .chk_valid(d_gv), .chk_data(d_gd ^ flip1),
        .err_clr(err_clr), .chk_locked(d_lk), .err_cnt(d_ec), .err_word(d_ew)
    );

    prbs_engine #(.STEP(2)) u_s2 (
        .clk(clk), .rst(rst), .gen_en(gen_en), .seed_load(seed_load), .seed_in(seed_in),
        .gen_data(s2_gd), .gen_valid(s2_gv), .chk_valid(s2_gv), .chk_data(s2_gd ^ flip2),
        .err_clr(err_clr), .chk_locked(s2_lk), .err_cnt(s2_ec), .err_word(s2_ew)
    );

    prbs_engine #(.STEP(4)) u_s4 (
        .clk(clk), .rst(rst), .gen_en(gen_en), .seed_load(seed_load), .seed_in(seed_in),
        .gen_data(s4_gd), .gen_valid(s4_gv), .chk_valid(1'b0), .chk_data(4'h0),
        .err_clr(1'b0), .chk_locked(s4_lk), .err_cnt(s4_ec), .err_word(s4_ew)
    );

    prbs_engine #(.WIDTH(31), .TAPS(31'h4800_0000), .STEP(8)) u_w31 (
        .clk(clk), .rst(rst), .gen_en(gen_en), .seed_load(seed_load), .seed_in({15'd0, seed_in}),
        .gen_data(w_gd), .gen_valid(w_gv), .chk_valid(1'b0), .chk_data(8'h00),
        .err_clr(1'b0), .chk_locked(w_lk), .err_cnt(w_ec), .err_word(w_ew)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Counts words sampled by the default checker until chk_locked rises.
    task automatic wait_lock(input string tag, input int exp_words);
        int  words;
        bit  got;
        logic v;
        words = 0;
        got   = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            v = d_gv;
            tick();
            if (v) words++;
            if (d_lk) got = 1'b1;
        end
        check(tag, got ? words : -1, exp_words);
    endtask

    initial begin
        int          drops;
        int          wbad;
        logic [30:0] ms;
        logic [7:0]  mw;
        logic        fb;

        rst = 1'b1; gen_en = 1'b0; seed_load = 1'b0; seed_in = '0;
        err_clr = 1'b0; flip1 = 1'b0; flip2 = '0;
        @(negedge clk);
        tick();
        check("rst_state", u_def.gen_state_q, 16'hFFFF);
        check("rst_gdata", d_gd, 0);
        check("rst_gvalid", d_gv, 0);
        check("rst_locked", d_lk, 0);
        check("rst_errcnt", d_ec, 0);
        check("rst_errword", d_ew, 0);

        rst = 1'b0; gen_en = 1'b1;
        tick();
        check("gen_state1", u_def.gen_state_q, 16'hFFFE);
        check("gen_valid1", d_gv, 1);
        check("gen_data1", d_gd, 0);
        check("s4_state", u_s4.gen_state_q, 16'hFFF0);
        check("s4_data", s4_gd, 4'h0);
        tick();
        check("gen_state2", u_def.gen_state_q, 16'hFFFC);
        tick();
        check("gen_state3", u_def.gen_state_q, 16'hFFF8);
        check("gen_valid3", d_gv, 1);
        gen_en = 1'b0;
        tick();
        check("gen_valid_off", d_gv, 0);
        check("gen_data_hold", d_gd, 0);

        seed_load = 1'b1; seed_in = 16'h0001;
        tick();
        seed_load = 1'b0;
        check("seed_0001", u_def.gen_state_q, 16'h0001);
        gen_en = 1'b1;
        tick();
        gen_en = 1'b0;
        check("seed_step", u_def.gen_state_q, 16'h0002);
        check("seed_data", d_gd, 0);
        check("seed_valid", d_gv, 1);
        seed_load = 1'b1; seed_in = 16'h0000;
        tick();
        check("seed_zero", u_def.gen_state_q, 16'hFFFF);
        seed_in = 16'h1234; gen_en = 1'b1;
        tick();
        seed_load = 1'b0; gen_en = 1'b0;
        check("load_wins", u_def.gen_state_q, 16'h1234);
        check("load_novalid", d_gv, 0);

        rst = 1'b1;
        tick();
        rst = 1'b0; gen_en = 1'b1;
        wait_lock("lock_words", 20);
        drops = 0;
        repeat (10000) begin
            tick();
            if (!d_lk) drops++;
        end
        check("lock_hold", drops, 0);
        check("lock_noerr", d_ec, 0);

        flip1 = 1'b1;
        tick();
        flip1 = 1'b0;
        check("err1_cnt", d_ec, 1);
        check("err1_word", d_ew, 1);
        check("err1_locked", d_lk, 1);
        tick();
        check("errword_pulse", d_ew, 0);

        err_clr = 1'b1; flip1 = 1'b1;
        tick();
        err_clr = 1'b0; flip1 = 1'b0;
        check("clr_with_err", d_ec, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_only", d_ec, 0);

        flip1 = 1'b1;
        tick(); tick(); tick();
        check("burst3_locked", d_lk, 1);
        tick();
        flip1 = 1'b0;
        check("burst4_unlock", d_lk, 0);
        check("burst4_cnt", d_ec, 4);
        wait_lock("relock_words", 20);

        repeat (3) begin
            flip1 = 1'b1;
            tick();
            flip1 = 1'b0;
            tick();
        end
        check("cnt7", d_ec, 7);
        check("cnt7_locked", d_lk, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_locked", d_lk, 0);
        check("midrst_cnt", d_ec, 0);

        repeat (30) tick();
        check("s2_locked", s2_lk, 1);
        force u_s2.err_q = 32'hFFFF_FFFE;
        #1;
        release u_s2.err_q;
        flip2 = 2'b11;
        tick();
        flip2 = 2'b00;
        check("sat_cnt", s2_ec, 32'hFFFF_FFFF);
        check("sat_word", s2_ew, 1);
        flip2 = 2'b01;
        tick();
        flip2 = 2'b00;
        check("sat_hold", s2_ec, 32'hFFFF_FFFF);

        gen_en = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; gen_en = 1'b1;
        ms   = '1;
        wbad = 0;
        for (int n = 0; n < 1000; n++) begin
            tick();
            for (int k = 0; k < 8; k++) begin
                fb        = ^(ms & 31'h4800_0000);
                ms        = {ms[29:0], fb};
                mw[7 - k] = fb;
            end
            if (w_gd !== mw || w_gv !== 1'b1) wbad++;
        end
        gen_en = 1'b0;
        check("w31_words", wbad, 0);
        check("w31_state", u_w31.gen_state_q, ms);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
